// File: rtl/time_display_mux.sv
// Captures a minutes/seconds pair, converts it to BCD one bit per cycle,
// and scans the four digits onto a multiplexed active-low 7-segment display.
module time_display_mux #(
  parameter int REFRESH_DIV = 1000,
  parameter bit BLANK_LEAD  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  input  logic       update,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [7:0]  min_snap_q, min_snap_d;
  logic [7:0]  sec_snap_q, sec_snap_d;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] dd_q, dd_d;
  logic [15:0] dd_in;
  logic [7:0]  min_bcd_q, min_bcd_d;
  logic [3:0]  min_t_q, min_t_d;
  logic [3:0]  min_o_q, min_o_d;
  logic [3:0]  sec_t_q, sec_t_d;
  logic [3:0]  sec_o_q, sec_o_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  digit_sel;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;

  // One shift-add-3 step on {tens, ones, binary}; values stay below 100.
  function automatic logic [15:0] dd_step(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    return {t[14:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d    = state_q;
    min_snap_d = min_snap_q;
    sec_snap_d = sec_snap_q;
    iter_d     = iter_q;
    dd_d       = dd_q;
    dd_in      = dd_q;
    min_bcd_d  = min_bcd_q;
    min_t_d    = min_t_q;
    min_o_d    = min_o_q;
    sec_t_d    = sec_t_q;
    sec_o_d    = sec_o_q;
    case (state_q)
      IDLE: begin
        if (update) begin
          state_d    = CONV;
          min_snap_d = (minutes > 8'd99) ? 8'd99 : minutes;
          sec_snap_d = (seconds > 8'd59) ? 8'd59 : seconds;
          iter_d     = 4'd0;
        end
      end
      CONV: begin
        // Iterations 0-7 convert minutes, 8-15 seconds; the shifter is reseeded at each start.
        if (iter_q == 4'd0)      dd_in = {8'h00, min_snap_q};
        else if (iter_q == 4'd8) dd_in = {8'h00, sec_snap_q};
        dd_d   = dd_step(dd_in);
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd7)  min_bcd_d = dd_d[15:8];
        if (iter_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        min_t_d = min_bcd_q[7:4];
        min_o_d = min_bcd_q[3:0];
        sec_t_d = dd_q[15:12];
        sec_o_d = dd_q[11:8];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q + 16'd1;
    idx_d     = idx_q;
    if (ref_cnt_q == 16'(REFRESH_DIV - 1)) begin
      ref_cnt_d = 16'd0;
      idx_d     = idx_q + 2'd1;
    end
    case (idx_d)
      2'd0:    digit_sel = sec_o_q;
      2'd1:    digit_sel = sec_t_q;
      2'd2:    digit_sel = min_o_q;
      default: digit_sel = min_t_q;
    endcase
    seg_d = seg_enc(digit_sel);
    if (BLANK_LEAD && idx_d == 2'd3 && min_t_q == 4'd0) seg_d = 7'b1111111;
    an_d = ~(4'b0001 << idx_d);
    dp_d = (idx_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      min_snap_q <= 8'd0;
      sec_snap_q <= 8'd0;
      iter_q     <= 4'd0;
      dd_q       <= 16'd0;
      min_bcd_q  <= 8'd0;
      min_t_q    <= 4'd0;
      min_o_q    <= 4'd0;
      sec_t_q    <= 4'd0;
      sec_o_q    <= 4'd0;
      ref_cnt_q  <= 16'd0;
      idx_q      <= 2'd0;
      seg_q      <= 7'b1000000;
      an_q       <= 4'b1110;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      min_snap_q <= min_snap_d;
      sec_snap_q <= sec_snap_d;
      iter_q     <= iter_d;
      dd_q       <= dd_d;
      min_bcd_q  <= min_bcd_d;
      min_t_q    <= min_t_d;
      min_o_q    <= min_o_d;
      sec_t_q    <= sec_t_d;
      sec_o_q    <= sec_o_d;
      ref_cnt_q  <= ref_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_time_display_mux.sv
// Randomised and directed bench for time_display_mux against a timing-level
// reference model of capture, conversion latency and display scanning.
module tb_time_display_mux;

  localparam int DIV = 4;
  localparam logic [6:0] SEG_TAB [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] minutes = 8'd0;
  logic [7:0] seconds = 8'd0;
  logic       update = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int errs = 0;
  int checks = 0;

  time_display_mux #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .minutes(minutes), .seconds(seconds),
    .update(update), .busy(busy), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d, input bit blank);
    return blank ? 7'b1111111 : SEG_TAB[d];
  endfunction

  // Reference model: edges since reset, the accepting edge, and shown digits.
  // Digits are indexed by scan position: 0=sec ones, 1=sec tens, 2=min ones, 3=min tens.
  int  k = 0;
  int  acc = -1000;
  int  shown [4];
  int  pend [4];
  int  mm, ss;
  int  exp_idx = 0;
  bit  exp_busy = 1'b0;
  bit  mvalid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      acc = -1000;
      shown = '{0, 0, 0, 0};
      mvalid = 1'b1;
    end else if (mvalid) begin
      k++;
      if (k == acc + 18) shown = pend;
      if (update && k >= acc + 18) begin
        acc = k;
        mm = (int'(minutes) > 99) ? 99 : int'(minutes);
        ss = (int'(seconds) > 59) ? 59 : int'(seconds);
        pend = '{ss % 10, ss / 10, mm % 10, mm / 10};
      end
    end
    exp_busy = mvalid && (k >= acc) && (k <= acc + 16);
    exp_idx = (k / DIV) % 4;
  end

  always @(negedge clk) begin
    logic [3:0] ea;
    if (mvalid) begin
      ea = ~(4'b0001 << exp_idx);
      chk("mon_busy", 32'(busy), 32'(exp_busy));
      chk("mon_an", 32'(an), 32'(ea));
      chk("mon_seg", 32'(seg), 32'(seg_of(shown[exp_idx], exp_idx == 3 && shown[3] == 0)));
      chk("mon_dp", 32'(dp), 32'(exp_idx != 2));
    end
  end

  task automatic do_update(input int m, input int s);
    @(negedge clk);
    minutes = 8'(m);
    seconds = 8'(s);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("idle_timeout", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_digit(input string tag, input logic [3:0] an_v, input logic [6:0] seg_e);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (an === an_v) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("an_timeout", 32'(an), 32'(an_v));
    else chk(tag, 32'(seg), 32'(seg_e));
  endtask

  task automatic chk_time(input int m, input int s);
    chk_digit("sec_o", 4'b1110, SEG_TAB[s % 10]);
    chk_digit("sec_t", 4'b1101, SEG_TAB[s / 10]);
    chk_digit("min_o", 4'b1011, SEG_TAB[m % 10]);
    chk_digit("min_t", 4'b0111, seg_of(m / 10, m / 10 == 0));
  endtask

  initial begin
    int n;
    int rm, rs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b1000000);
    chk("rst_dp", 32'(dp), 32'd1);
    rst_n = 1'b1;

    do_update(12, 34);
    count_busy(n);
    chk("busy_len_1234", 32'(n), 32'd17);
    @(negedge clk);
    chk_digit("an1_seg_3", 4'b1101, 7'b0110000);
    chk_time(12, 34);

    do_update(0, 5);
    wait_idle();
    chk_digit("blank_lead", 4'b0111, 7'b1111111);
    chk_digit("min_o_zero", 4'b1011, 7'b1000000);
    chk("dp_sep", 32'(dp), 32'd0);

    do_update(150, 75);
    wait_idle();
    chk_time(99, 59);

    // Second request five edges into the first conversion must be dropped.
    do_update(2, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) begin minutes = 8'd1; update = 1'b1; end
      if (i == 5) update = 1'b0;
      if (busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    update = 1'b0;
    chk("busy_len_ignored", 32'(n), 32'd17);
    @(negedge clk);
    chk_time(2, 0);

    chk_digit("seq_start", 4'b0111, 7'b1111111);
    chk_digit("seq_wrap", 4'b1110, 7'b1000000);
    for (int j = 0; j < 5; j++) begin
      for (int c = 0; c < DIV; c++) begin
        chk("an_seq", 32'(an), 32'(4'(~(4'b0001 << (j % 4)))));
        @(negedge clk);
      end
    end

    do_update(45, 23);
    repeat (8) @(negedge clk);
    chk("busy_mid_conv", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_an", 32'(an), 32'b1110);
    chk("abort_seg", 32'(seg), 32'b1000000);
    repeat (20) @(negedge clk);
    chk_time(0, 0);

    do_update(99, 59);
    wait_idle();
    chk_time(99, 59);
    do_update(100, 60);
    wait_idle();
    chk_time(99, 59);

    for (int r = 0; r < 30; r++) begin
      rm = int'($urandom_range(0, 255));
      rs = int'($urandom_range(0, 255));
      do_update(rm, rs);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/time_display_mux.md
TIME_DISPLAY_MUX -- requirements
Module: time_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000, clk cycles each digit is driven (legal range 2..65535).
REQ-002 SHALL have parameter BLANK_LEAD, default 1, 1 = blank the minutes-tens digit when it is zero.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port minutes  input  8  binary minutes from the minutes counter, nominal 0..99.
REQ-006 SHALL have port seconds  input  8  binary seconds from the seconds counter, nominal 0..59.
REQ-007 SHALL have port update  input  1  request to capture minutes/seconds and refresh the display.
REQ-008 SHALL have port busy  output  1  high while a capture/conversion is in progress.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port an  output  4  digit enables, one-hot active-low; an[0] = seconds ones, an[3] = minutes tens.
REQ-011 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-012 SHALL use FSM states IDLE, CONV, DONE; update sampled high in IDLE registers min_snap/sec_snap and moves to CONV next edge; update in CONV or DONE is ignored (no queueing).
REQ-013 SHALL clamp on capture: minutes > 99 -> 99; seconds > 59 -> 59.
REQ-014 SHALL in CONV run sequential double-dabble (shift-add-3): 8 iterations on min_snap, then 8 on sec_snap, one iteration per cycle, 16 CONV cycles total.
REQ-015 SHALL after the 16th CONV cycle enter DONE for one cycle, loading all four digit registers (min_t, min_o, sec_t, sec_o) in that single edge, then return to IDLE.
REQ-016 SHALL keep displayed digits unchanged during CONV; no partially converted value is ever visible.
REQ-017 SHALL assert busy from the edge after update is accepted through the DONE cycle inclusive (17 cycles); busy low in IDLE.
REQ-018 SHALL have latency: update high at edge N -> new digits visible on seg at edge N+18; a new update is accepted at edge N+18 at the earliest.
REQ-019 SHALL run refresh counter 0..REFRESH_DIV-1 continuously, independent of FSM; on wrap, digit index advances 0->1->2->3->0.
REQ-020 SHALL drive an = ~(1 << index) and seg = encoding of the selected digit, both registered, changing on the same edge.
REQ-021 SHALL encode 0..9 active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 SHALL drive dp = 0 only when index = 2 (separator between minutes and seconds), otherwise 1.
REQ-023 SHALL drive seg = 1111111 for index 3 when BLANK_LEAD = 1 and min_t = 0; an still asserted.
REQ-024 SHALL have no combinational path from any input to seg, an, dp or busy.

Reset
REQ-025 SHALL on rst_n low at an edge: FSM = IDLE, busy = 0, snapshots and all digit registers = 0, refresh counter = 0, index = 0.
REQ-026 SHALL output after reset an = 1110, seg = 1000000, dp = 1.
REQ-027 SHALL have reset take priority over update and abort an in-flight conversion with no digit register changed except to 0.

Verification
REQ-028 SHALL cover: reset, then update with minutes=12, seconds=34 -> busy high 17 cycles, at N+18 digits 1,2,3,4; an[1] low shows seg 0110000.
REQ-029 SHALL cover: minutes=0, seconds=5, BLANK_LEAD=1 -> an[3] low shows seg 1111111; an[2] low shows 1000000 with dp=0.
REQ-030 SHALL cover: minutes=150, seconds=75 -> clamped display 99:59.
REQ-031 SHALL cover: second update (minutes=1) pulsed 5 cycles after first (minutes=2) -> ignored; display shows 02 minutes; busy stays high only 17 cycles.
REQ-032 SHALL cover: REFRESH_DIV=4 -> an sequence 1110,1101,1011,0111,1110 each held exactly 4 cycles.
REQ-033 SHALL cover: rst_n low at CONV cycle 8 -> next edge busy=0, all digits 0, an=1110.
